// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the byte-serial memory controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam int DataBus     = 32;
    localparam int RamAddrBus  = 17;

    localparam logic [1:0] MemByte = 2'b00;
    localparam logic [1:0] MemHalf = 2'b01;
    localparam logic [1:0] MemWord = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR,
        HOLD
    } state_t;

    // Bytes moved for a MEM transfer; the unused encoding 2'b11 behaves as a word.
    function automatic logic [2:0] xfer_len(input logic [1:0] width);
        case (width)
            MemByte: return 3'd1;
            MemHalf: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if_buf.sv
// One-entry fetch buffer: remembers {valid, addr, inst} of the last completed fetch.
// Latency: hit/inst are combinational from the stored entry; updates land on the next edge.
// Backpressure: none; clr (store accepted) wins over upd.
// Ports: upd/upd_addr/upd_inst load the entry, clr invalidates it,
//        look_addr is compared against the entry to give hit, inst is the stored word.
module mem_ctrl_if_buf
    import mem_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   upd,
    input  logic [InstAddrBus-1:0] upd_addr,
    input  logic [InstBus-1:0]     upd_inst,
    input  logic                   clr,
    input  logic [InstAddrBus-1:0] look_addr,
    output logic                   hit,
    output logic [InstBus-1:0]     inst
);
    logic                   buf_vld;
    logic [InstAddrBus-1:0] buf_addr;
    logic [InstBus-1:0]     buf_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_vld  <= 1'b0;
            buf_addr <= '0;
            buf_dat  <= '0;
        end else if (clr) begin
            buf_vld <= 1'b0;
        end else if (upd) begin
            buf_vld  <= 1'b1;
            buf_addr <= upd_addr;
            buf_dat  <= upd_inst;
        end
    end

    assign hit  = buf_vld && (buf_addr == look_addr);
    assign inst = buf_dat;

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: serialises IF fetches and MEM loads/stores onto a byte-wide RAM, MEM first.
// Latency: read of n bytes done after T+n+1, write after T+n (T = accepting edge); buffered fetch hit T+1.
// Backpressure: requesters hold req until their one-cycle done; a missing done is the stall.
// Ports: clk/rst; IF side if_req/if_addr/br -> if_mem_ctrl_done/if_rdata;
//        MEM side mem_req/mem_we/mem_width/mem_addr/mem_wdata -> mem_done/mem_rdata;
//        RAM side ram_a/ram_wr/ram_dout out, ram_din in (one cycle after its address).
// Option: MEM_CTRL_IF_BUF_EN adds a one-entry fetch buffer (mem_ctrl_if_buf).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = RamAddrBus
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [InstAddrBus-1:0] if_addr,
    input  logic                   br,
    output logic                   if_mem_ctrl_done,
    output logic [InstBus-1:0]     if_rdata,
    input  logic                   mem_req,
    input  logic                   mem_we,
    input  logic [1:0]             mem_width,
    input  logic [DataBus-1:0]     mem_addr,
    input  logic [DataBus-1:0]     mem_wdata,
    output logic                   mem_done,
    output logic [DataBus-1:0]     mem_rdata,
    output logic [ADDR_W-1:0]      ram_a,
    output logic                   ram_wr,
    output logic [7:0]             ram_dout,
    input  logic [7:0]             ram_din
);
    state_t              state, state_nxt;
    logic [2:0]          cnt;
    logic [2:0]          len;
    logic [1:0]          rd_sel;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                is_mem;
    logic                hit_q;
    logic [1:0]          width_r;
    logic [DataBus-1:0]  wdata_r;
    logic [DataBus-1:0]  rbuf;
    logic [DataBus-1:0]  rd_word;
    logic                last_rd;
    logic                last_wr;
    logic                buf_hit;
    logic [InstBus-1:0]  buf_inst;
    logic                unused_addr_hi;

    // Byte addresses wrap silently at 2^ADDR_W, so the upper request bits never matter.
    assign unused_addr_hi = ^{mem_addr[DataBus-1:ADDR_W], if_addr[InstAddrBus-1:ADDR_W]};

    assign len      = is_mem ? xfer_len(width_r) : 3'd4;
    assign addr_nxt = base + ADDR_W'(cnt) + ADDR_W'(1);
    // Reads run one step past the last address because ram_din lags ram_a by a cycle.
    assign last_rd  = (cnt == len);
    assign last_wr  = (cnt == len - 3'd1);
    assign rd_sel   = 2'(cnt - 3'd1);

    // Merge the byte now on ram_din (belonging to address cnt-1) into the partial word.
    always_comb begin
        rd_word = rbuf;
        if (cnt != 3'd0) begin
            rd_word[{rd_sel, 3'b000} +: 8] = ram_din;
        end
    end

    assign ram_wr           = (state == MEM_WR);
    assign ram_dout         = ram_wr ? wdata_r[{cnt[1:0], 3'b000} +: 8] : 8'h00;
    assign if_mem_ctrl_done = (state == HOLD) && !is_mem;
    assign mem_done         = (state == HOLD) && is_mem;

`ifdef MEM_CTRL_IF_BUF_EN
    logic buf_upd;
    logic buf_clr;

    assign buf_upd = (state == IF_RD) && !br && !hit_q && last_rd;
    assign buf_clr = (state == IDLE) && mem_req && mem_we;

    mem_ctrl_if_buf u_if_buf (
        .clk       (clk),
        .rst       (rst),
        .upd       (buf_upd),
        .upd_addr  (if_addr),
        .upd_inst  (rd_word),
        .clr       (buf_clr),
        .look_addr (if_addr),
        .hit       (buf_hit),
        .inst      (buf_inst)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_inst = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_nxt = mem_we ? MEM_WR : MEM_RD;
                end else if (if_req && !br) begin
                    state_nxt = IF_RD;
                end
            end
            // A buffered hit spends one IF_RD cycle with no RAM traffic, then completes.
            IF_RD:   if (br) state_nxt = IDLE;
                     else if (hit_q || last_rd) state_nxt = HOLD;
            MEM_RD:  if (last_rd) state_nxt = HOLD;
            MEM_WR:  if (last_wr) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            base      <= '0;
            is_mem    <= 1'b0;
            hit_q     <= 1'b0;
            width_r   <= MemByte;
            wdata_r   <= '0;
            rbuf      <= '0;
            ram_a     <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    rbuf <= '0;
                    if (mem_req) begin
                        base    <= mem_addr[ADDR_W-1:0];
                        ram_a   <= mem_addr[ADDR_W-1:0];
                        is_mem  <= 1'b1;
                        hit_q   <= 1'b0;
                        width_r <= mem_width;
                        wdata_r <= mem_wdata;
                    end else if (if_req && !br) begin
                        is_mem <= 1'b0;
                        hit_q  <= buf_hit;
                        // A hit leaves ram_a untouched: no RAM access is made.
                        if (!buf_hit) begin
                            base  <= if_addr[ADDR_W-1:0];
                            ram_a <= if_addr[ADDR_W-1:0];
                        end
                    end
                end
                IF_RD: begin
                    if (!br) begin
                        if (hit_q) begin
                            if_rdata <= buf_inst;
                        end else begin
                            rbuf <= rd_word;
                            cnt  <= cnt + 3'd1;
                            if (last_rd) if_rdata <= rd_word;
                            else         ram_a    <= addr_nxt;
                        end
                    end
                end
                MEM_RD: begin
                    rbuf <= rd_word;
                    cnt  <= cnt + 3'd1;
                    if (last_rd) mem_rdata <= rd_word;
                    else         ram_a     <= addr_nxt;
                end
                MEM_WR: begin
                    cnt <= cnt + 3'd1;
                    if (!last_wr) ram_a <= addr_nxt;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
module tb_mem_ctrl;
    localparam int          AW    = 17;
    localparam int          RAM_N = 1 << AW;
    localparam logic [31:0] AMASK = 32'(RAM_N - 1);
`ifdef MEM_CTRL_IF_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          br = 1'b0;
    logic          if_mem_ctrl_done;
    logic [31:0]   if_rdata;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [1:0]    mem_width = 2'b00;
    logic [31:0]   mem_addr = '0;
    logic [31:0]   mem_wdata = '0;
    logic          mem_done;
    logic [31:0]   mem_rdata;
    logic [AW-1:0] ram_a;
    logic          ram_wr;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .br(br),
        .if_mem_ctrl_done(if_mem_ctrl_done), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    // Synchronous byte RAM: data for the address seen at an edge appears after that edge.
    logic [7:0] ram [RAM_N];
    initial begin
        logic [7:0] rd_b;
        for (int i = 0; i < RAM_N; i++) ram[i] = init_byte(i);
        forever begin
            @(posedge clk);
            rd_b = ram[ram_a];
            if (ram_wr) ram[ram_a] = ram_dout;
            ram_din <= rd_b;
        end
    end

    // Reference model: expected memory image plus the fetch-buffer contents.
    logic [7:0]  ref_mem [RAM_N];
    bit          mdl_buf_vld = 1'b0;
    logic [31:0] mdl_buf_addr = '0;

    typedef struct {
        bit          is_mem;
        bit          chk_data;
        logic [31:0] data;
        int          done_cyc;
        bit          chk_ra;
        logic [AW-1:0] ra;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : ((w == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(a + 32'(k)) & AMASK];
        return v;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    logic prev_if_done = 1'b0;
    logic prev_mem_done = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        logic dbl;
        if (!rst && (mem_done || if_mem_ctrl_done)) begin
            n_done++;
            dbl = (mem_done && prev_mem_done) || (if_mem_ctrl_done && prev_if_done);
            check("done_pulse_width", {31'd0, dbl}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", {30'd0, mem_done, if_mem_ctrl_done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_port", {30'd0, mem_done, if_mem_ctrl_done}, e.is_mem ? 32'd2 : 32'd1);
                check("done_cycle", cyc, e.done_cyc);
                if (e.chk_data)
                    check(e.is_mem ? "mem_rdata" : "if_rdata", e.is_mem ? mem_rdata : if_rdata, e.data);
                if (e.chk_ra)
                    check("ram_a_held_on_hit", 32'(ram_a), 32'(e.ra));
            end
        end
        prev_if_done  = if_mem_ctrl_done;
        prev_mem_done = mem_done;
    end

    // Issue an IF fetch, a MEM access, or both together; expectations come from the model.
    task automatic run_tx(input bit do_if, input logic [31:0] ia, input bit do_mem,
                          input bit we, input logic [1:0] w, input logic [31:0] ma,
                          input logic [31:0] wd);
        exp_t e;
        int   t_acc, t_if, n, budget;
        bit   hit;
        @(negedge clk);
        t_acc = cyc + 1;
        t_if  = t_acc;
        if (do_mem) begin
            n = nbytes(w);
            e.is_mem = 1'b1; e.chk_data = !we; e.data = '0; e.chk_ra = 1'b0; e.ra = '0;
            if (we) begin
                for (int k = 0; k < n; k++) ref_mem[(ma + 32'(k)) & AMASK] = wd[8*k +: 8];
                mdl_buf_vld = 1'b0;
                e.done_cyc = t_acc + n;
            end else begin
                e.data = ref_load(ma, n);
                e.done_cyc = t_acc + n + 1;
            end
            exp_q.push_back(e);
            // IF waits through MEM's done cycle and one idle cycle.
            t_if = e.done_cyc + 2;
        end
        if (do_if) begin
            hit = BUF_EN && mdl_buf_vld && (mdl_buf_addr == ia);
            e.is_mem = 1'b0; e.chk_data = 1'b1; e.data = ref_load(ia, 4);
            e.done_cyc = t_if + (hit ? 1 : 5);
            e.chk_ra = hit && !do_mem;
            e.ra = ram_a;
            exp_q.push_back(e);
            if (BUF_EN) begin
                mdl_buf_vld = 1'b1;
                mdl_buf_addr = ia;
            end
        end
        if_req = do_if; if_addr = ia;
        mem_req = do_mem; mem_we = we; mem_width = w; mem_addr = ma; mem_wdata = wd;
        budget = 0;
        while ((if_req || mem_req) && budget < 60) begin
            @(negedge clk);
            budget++;
            if (mem_done) mem_req = 1'b0;
            if (if_mem_ctrl_done) if_req = 1'b0;
        end
        check("tx_complete", {30'd0, if_req, mem_req}, 32'd0);
        if_req = 1'b0;
        mem_req = 1'b0;
    endtask

    logic [31:0] pool [4] = '{32'h10, 32'h200, 32'h1FFFE, 32'h3000};

    initial begin : main
        int          d0, kind, mism;
        logic [31:0] ia, ma;
        for (int i = 0; i < RAM_N; i++) ref_mem[i] = init_byte(i);

        #2 rst = 1'b1;
        #1;
        check("rst_if_done", {31'd0, if_mem_ctrl_done}, 32'd0);
        check("rst_mem_done", {31'd0, mem_done}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        check("rst_ram_a", 32'(ram_a), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Instruction 0x00000513 placed at 0x10 (bytes 13 05 00 00), then fetched.
        run_tx(0, 32'h0, 1, 1, 2'b10, 32'h10, 32'h0000_0513);
        run_tx(1, 32'h10, 0, 0, 2'b00, 32'h0, 32'h0);
        // Byte store and fetch raised together: store goes first.
        run_tx(1, 32'h10, 1, 1, 2'b00, 32'h20, 32'h0000_00AB);
        check("ram_0x20", {24'd0, ram[32'h20]}, 32'h0000_00AB);
        // Half accesses, including one straddling the top of the address space.
        run_tx(0, 32'h0, 1, 1, 2'b01, 32'h30, 32'h0000_FFFE);
        run_tx(0, 32'h0, 1, 0, 2'b01, 32'h30, 32'h0);
        run_tx(0, 32'h0, 1, 1, 2'b01, 32'h1FFFF, 32'h0000_1234);
        run_tx(0, 32'h0, 1, 0, 2'b01, 32'h1FFFF, 32'h0);
        run_tx(0, 32'h0, 1, 0, 2'b00, 32'h0, 32'h0);
        run_tx(0, 32'h0, 1, 0, 2'b11, 32'h1FFFE, 32'h0);
        // Repeated fetch (buffer hit when enabled), then invalidation by a store.
        run_tx(1, 32'h10, 0, 0, 2'b00, 32'h0, 32'h0);
        run_tx(1, 32'h10, 0, 0, 2'b00, 32'h0, 32'h0);
        run_tx(0, 32'h0, 1, 1, 2'b00, 32'h50, 32'h0000_0077);
        run_tx(1, 32'h10, 0, 0, 2'b00, 32'h0, 32'h0);

        // Branch on the third IF_RD cycle aborts the fetch with no done.
        @(negedge clk);
        d0 = n_done;
        if_addr = 32'h100; if_req = 1'b1;
        repeat (3) @(negedge clk);
        br = 1'b1; if_req = 1'b0;
        @(negedge clk);
        br = 1'b0;
        repeat (8) @(negedge clk);
        check("br_no_done", n_done, d0);
        run_tx(1, 32'h200, 0, 0, 2'b00, 32'h0, 32'h0);

        // Reset while byte 1 of a word store is on the bus: only byte 0 lands.
        @(negedge clk);
        mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF; mem_we = 1'b1; mem_width = 2'b10;
        mem_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; mem_req = 1'b0;
        #1;
        check("midrst_mem_done", {31'd0, mem_done}, 32'd0);
        check("midrst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("midrst_ram_dout", {24'd0, ram_dout}, 32'd0);
        check("midrst_ram_a", 32'(ram_a), 32'd0);
        check("midrst_mem_rdata", mem_rdata, 32'd0);
        check("midrst_if_rdata", if_rdata, 32'd0);
        ref_mem[32'h40] = 8'hEF;
        mdl_buf_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ram_0x41", {24'd0, ram[32'h41]}, {24'd0, init_byte(32'h41)});
        run_tx(0, 32'h0, 1, 0, 2'b10, 32'h40, 32'h0);
        run_tx(1, 32'h10, 0, 0, 2'b00, 32'h0, 32'h0);

        // Randomised mix of fetches, loads, stores and simultaneous requests.
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            ia = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : $urandom();
            ma = ($urandom_range(0, 7) == 0) ? (32'h1FFFC + 32'($urandom_range(0, 3))) : $urandom();
            run_tx(kind != 1, ia, kind != 0, 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), ma, $urandom());
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        mism = 0;
        for (int i = 0; i < RAM_N; i++) if (ram[i] !== ref_mem[i]) mism++;
        check("ram_image_mismatches", mism, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
